// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Imported by the picker and the arbiter top.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_M0   = 2'b01;
    localparam logic [1:0] G_M1   = 2'b10;

    localparam int TIMEOUT_DEFAULT = 16;

    // One master's request bundle as seen by the slave-side mux.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic        stb;
    } mreq_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served
// last wins; a single requester always wins.
module rr_pick2
    import mio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = G_NONE;
        case (req)
            2'b01:   grant = G_M0;
            2'b10:   grant = G_M1;
            2'b11:   grant = last ? G_M0 : G_M1;
            default: grant = G_NONE;
        endcase
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master / one-slave Wishbone-classic arbiter: request phase, one-cycle
// response phase, round-robin fairness and a no-ack timeout.
module wb_master_arbiter
    import mio_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m0_adr_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_dat_i,
    input  logic [31:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_dat_o,
    output logic [31:0] s_adr_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    mreq_t      m_req [2];
    logic [1:0] m_stb;
    logic [1:0] pick;
    logic       owner_idx;
    mreq_t      owner_req;
    logic [1:0] m_ack;
    logic [1:0] m_err;
    logic [31:0] m_rdat [2];

    assign m_req[0] = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i, stb: m0_stb_i};
    assign m_req[1] = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i, stb: m1_stb_i};
    assign m_stb    = {m1_stb_i, m0_stb_i};

    // owner_q is one-hot whenever it is non-zero, so bit 1 names the owner.
    assign owner_idx = owner_q[1];
    assign owner_req = m_req[owner_idx];

    rr_pick2 u_pick (
        .req   (m_stb),
        .last  (last_q),
        .grant (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= G_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                owner_d = G_NONE;
                if (|m_stb) begin
                    owner_d = pick;
                    state_d = REQ;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                if (s_ack_i) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (!owner_req.stb) begin
                    // Abandoned transfer still counts as a turn for fairness.
                    state_d = IDLE;
                    owner_d = G_NONE;
                    last_d  = owner_idx;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = G_NONE;
                last_d  = owner_idx;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                owner_d = G_NONE;
            end
        endcase
    end

    // Slave side: driven only in REQ, so RESP never re-strobes the slave.
    always_comb begin
        s_stb_o = 1'b0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_dat_o = '0;
        if (state_q == REQ) begin
            s_stb_o = owner_req.stb;
            s_adr_o = owner_req.adr;
            s_we_o  = owner_req.we;
            s_dat_o = owner_req.dat;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        logic resp_here;
        assign resp_here  = (state_q == RESP) && owner_q[gi];
        assign m_ack[gi]  = resp_here && !err_q;
        assign m_err[gi]  = resp_here &&  err_q;
        assign m_rdat[gi] = resp_here ? s_dat_i : '0;
    end

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_dat_o = m_rdat[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_dat_o = m_rdat[1];

    assign grant = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone-classic arbiter that shares the memory-mapped I/O bus (LEDs, 7-seg, counter) between the CPU data port (m0) and a secondary master such as a debug/DMA engine (m1).
- Sequences every transfer as a request phase followed by a response phase. This matches the slave, which acks combinationally and registers its read data one cycle after the ack.
- Provides round-robin fairness and a timeout that returns an error when the slave never acks.

Parameters:
TIMEOUT, 16, cycles in REQ without s_ack_i before the arbiter aborts with an error (legal range 1..255).
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-low reset.
m0_dat_i  in  32  master 0 write data.
m0_adr_i  in  32  master 0 address.
m0_we_i  in  1  master 0 write enable.
m0_stb_i  in  1  master 0 strobe/request; held until ack or err.
m0_dat_o  out  32  master 0 read data.
m0_ack_o  out  1  master 0 transfer done.
m0_err_o  out  1  master 0 timeout error.
m1_dat_i, m1_adr_i, m1_we_i, m1_stb_i, m1_dat_o, m1_ack_o, m1_err_o: same widths and meaning for master 1.
s_dat_o  out  32  write data to slave.
s_adr_o  out  32  address to slave.
s_we_o  out  1  write enable to slave.
s_stb_o  out  1  strobe to slave.
s_dat_i  in  32  slave read data, registered by the slave and valid the cycle after ack.
s_ack_i  in  1  slave ack.
grant  out  2  one-hot current owner; 00 when idle.
busy  out  1  high in REQ and RESP.

Behaviour:
- State machine states:
  - IDLE: no owner; all slave outputs are 0.
  - REQ: owner's adr/we/dat are muxed to the slave; s_stb_o = owner stb.
  - RESP: one cycle; ack or err pulses to the owner.
- Reset (rst=0 at a rising edge):
  - state=IDLE, grant=00, last=1 (so m0 wins the first tie), timeout counter=0, err flag=0.
  - All outputs are 0 in the following cycle, including any s_stb_o that was mid-transfer. Any transfer in flight is dropped with no ack.
- IDLE transitions:
  - If either stb is high, latch owner = round-robin pick and go to REQ. The pick is the requester other than `last` if both request, else the single requester.
  - If no stb, stay in IDLE.
- REQ transitions:
  - s_ack_i=1: go to RESP with err flag=0.
  - Owner stb drops (abort): go to IDLE with no response; last is still updated to the owner.
  - Counter reaches TIMEOUT-1 without ack: go to RESP with err flag=1.
  - Otherwise increment the counter.
  - The counter clears on entry to REQ.
- RESP behaviour:
  - Owner ack_o = ~err flag; owner err_o = err flag.
  - Owner dat_o = s_dat_i; the non-owner's dat_o is 0.
  - last <= owner; next state is IDLE.
  - s_stb_o=0 in RESP, so the slave never sees a second strobe for the same transfer.
- Latency with an immediate slave ack: request seen in cycle N, slave strobe in N+1, master ack in N+2, next arbitration in N+3. Sustained throughput is one transfer per 3 cycles.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …
- A new request in RESP is ignored until IDLE.
- Write data reaches the slave during REQ; the slave latches it on the ack edge. A timed-out write may or may not have taken effect; the master is told by err_o.
- ack_o and err_o are never both high, and never reach the non-owner.

Decomposition:
- Shared package `mio_arb_pkg`:
  - State encoding: IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - Grant encodings: G_NONE=2'b00, G_M0=2'b01, G_M1=2'b10.
  - Default TIMEOUT constant.
- One sub-module `rr_pick2`: combinational round-robin picker (req[1:0], last → onehot grant), instanced once.

Test Plan:
- m0 write 0x000000AA to 0xFFFFFF00, slave acks immediately → s_stb_o high exactly 1 cycle with s_adr_o=0xFFFFFF00, s_we_o=1; m0_ack_o pulses 2 cycles after stb rise; m1 outputs stay 0.
- m1 read 0xFFFFFE00, slave returns 0x12345678 the cycle after ack → m1_dat_o=0x12345678 with m1_ack_o=1 in RESP; grant=10 during REQ and RESP.
- Both stb high from the cycle after reset for 4 transfers → owner order m0, m1, m0, m1; each ack 3 cycles apart.
- Slave never acks, TIMEOUT=16 → m0_err_o pulses once after 16 REQ cycles, m0_ack_o stays 0, busy returns to 0; the next m1 request is served normally.
- rst=0 asserted in the middle of REQ → s_stb_o, grant and busy are 0 the next cycle; no ack/err issued; the first request after release goes to m0 on a tie.
- m0 drops stb in REQ before ack → return to IDLE with no ack; a pending m1 request is granted next.
